// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and defaults for the hazard scoreboard unit.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
package hazard_scoreboard_unit_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DATA   = 2'd1,
        HZ_FREEZE = 2'd2,
        HZ_FLUSH  = 2'd3
    } hz_state_e;

    localparam int DEF_ALU_USE_DELAY   = 0;
    localparam int DEF_LOAD_USE_DELAY  = 1;
    localparam int DEF_NOFWD_USE_DELAY = 3;
    localparam int DEF_STALL_TIMEOUT   = 64;

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_counter.sv
// One scoreboard entry: cycles remaining until a register's pending result is usable.
// Loads on issue, holds on freeze, otherwise counts down and sticks at zero.
module hazard_pending_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] count_o,
    output logic          pending_o
);

    logic [CW-1:0] count_d, count_q;

    // NOTE: count_d gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (!hold_i) begin
            if (count_q != '0) count_d = count_q - 1'b1;
            if (load_i)        count_d = load_val_i;
        end
    end

    // NOTE: state flops use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o   = count_q;
    assign pending_o = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based hazard unit: per-register pending counters drive PC/IF-ID/ID-EX controls.
// Define HAZARD_STATS_EN to add saturating stall/freeze/flush statistics outputs.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NUM_REGS        = 4,
    parameter int REG_AW          = 2,
    parameter int DATA_FORWARDING = 1,
    parameter int ALU_USE_DELAY   = DEF_ALU_USE_DELAY,
    parameter int LOAD_USE_DELAY  = DEF_LOAD_USE_DELAY,
    parameter int NOFWD_USE_DELAY = DEF_NOFWD_USE_DELAY,
    parameter int STALL_TIMEOUT   = DEF_STALL_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_is_load,
    input  logic              jump_miss,
    input  logic              i_branch_miss,
    input  logic              mem_stall,
    output logic              pc_write,
    output logic              ir_write,
    output logic              stall_IFID,
    output logic              stall_IDEX,
    output logic              flush_IFID,
    output logic              flush_IDEX,
    output logic [1:0]        hazard_state,
    output logic              hazard_error
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stat_stall_cycles,
    output logic [15:0]       stat_freeze_cycles,
    output logic [15:0]       stat_flushes
`endif
);

    localparam int MAX_DELAY = (DATA_FORWARDING != 0) ? max2(ALU_USE_DELAY, LOAD_USE_DELAY)
                                                      : NOFWD_USE_DELAY;
    localparam int CW = cnt_width(MAX_DELAY);
    localparam int SW = cnt_width(STALL_TIMEOUT);

    localparam logic [CW-1:0] L_ALU   = CW'(ALU_USE_DELAY);
    localparam logic [CW-1:0] L_LOAD  = CW'(LOAD_USE_DELAY);
    localparam logic [CW-1:0] L_NOFWD = CW'(NOFWD_USE_DELAY);
    localparam logic [SW-1:0] TIMEOUT = SW'(STALL_TIMEOUT);

    logic [NUM_REGS-1:0]   pend;
    logic [CW-1:0]         cnt [NUM_REGS];
    logic [2**REG_AW-1:0]  pend_ext;
    logic                  freeze, flush, dhaz, issue;
    logic [CW-1:0]         issue_delay;
    hz_state_e             hz_class, hazard_state_q;
    logic [SW-1:0]         stall_run_d, stall_run_q;
    logic                  hazard_error_d, hazard_error_q;

    // Addresses beyond NUM_REGS see a zero-extended pending vector.
    always_comb begin
        pend_ext                 = '0;
        pend_ext[NUM_REGS-1:0]   = pend;
    end

    assign freeze = mem_stall;
    assign flush  = jump_miss | i_branch_miss;
    assign dhaz   = id_valid & ((id_use_rs & pend_ext[id_rs]) | (id_use_rt & pend_ext[id_rt]));
    assign issue  = id_valid & id_reg_write & ~freeze & ~flush & ~dhaz;

    always_comb begin
        if (DATA_FORWARDING != 0) issue_delay = id_is_load ? L_LOAD : L_ALU;
        else                      issue_delay = L_NOFWD;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        hazard_pending_counter #(.CW(CW)) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .hold_i     (freeze),
            .load_i     (issue && (id_dest == REG_AW'(g))),
            .load_val_i (issue_delay),
            .count_o    (cnt[g]),
            .pending_o  (pend[g])
        );
    end

    always_comb begin
        if (freeze)     hz_class = HZ_FREEZE;
        else if (flush) hz_class = HZ_FLUSH;
        else if (dhaz)  hz_class = HZ_DATA;
        else            hz_class = HZ_RUN;
    end

    always_comb begin
        pc_write   = 1'b1;
        ir_write   = 1'b1;
        stall_IFID = 1'b0;
        stall_IDEX = 1'b0;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        unique case (hz_class)
            HZ_FREEZE: begin
                pc_write   = 1'b0;
                ir_write   = 1'b0;
                stall_IFID = 1'b1;
                stall_IDEX = 1'b1;
            end
            HZ_FLUSH: begin
                flush_IFID = 1'b1;
                flush_IDEX = 1'b1;
            end
            HZ_DATA: begin
                pc_write   = 1'b0;
                ir_write   = 1'b0;
                stall_IFID = 1'b1;
                flush_IDEX = 1'b1;
            end
            default: ;
        endcase
    end

    // Freeze cycles leave the consecutive-stall run untouched.
    always_comb begin
        stall_run_d    = stall_run_q;
        hazard_error_d = hazard_error_q;
        unique case (hz_class)
            HZ_DATA:   if (stall_run_q != TIMEOUT) stall_run_d = stall_run_q + 1'b1;
            HZ_FREEZE: ;
            default:   stall_run_d = '0;
        endcase
        if (stall_run_d == TIMEOUT) hazard_error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hazard_state_q <= HZ_RUN;
            stall_run_q    <= '0;
            hazard_error_q <= 1'b0;
        end else begin
            hazard_state_q <= hz_class;
            stall_run_q    <= stall_run_d;
            hazard_error_q <= hazard_error_d;
        end
    end

    assign hazard_state = hazard_state_q;
    assign hazard_error = hazard_error_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stat_stall_d, stat_stall_q;
    logic [15:0] stat_freeze_d, stat_freeze_q;
    logic [15:0] stat_flush_d, stat_flush_q;

    always_comb begin
        stat_stall_d  = stat_stall_q;
        stat_freeze_d = stat_freeze_q;
        stat_flush_d  = stat_flush_q;
        if (hz_class == HZ_DATA   && stat_stall_q  != 16'hFFFF) stat_stall_d  = stat_stall_q + 1'b1;
        if (hz_class == HZ_FREEZE && stat_freeze_q != 16'hFFFF) stat_freeze_d = stat_freeze_q + 1'b1;
        if (hz_class == HZ_FLUSH  && stat_flush_q  != 16'hFFFF) stat_flush_d  = stat_flush_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall_q  <= '0;
            stat_freeze_q <= '0;
            stat_flush_q  <= '0;
        end else begin
            stat_stall_q  <= stat_stall_d;
            stat_freeze_q <= stat_freeze_d;
            stat_flush_q  <= stat_flush_d;
        end
    end

    assign stat_stall_cycles  = stat_stall_q;
    assign stat_freeze_cycles = stat_freeze_q;
    assign stat_flushes       = stat_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: three hazard_scoreboard_unit builds (forwarding, no forwarding, short watchdog)
// share one stimulus bus; each scenario checks the instance it targets.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
    logic [1:0] id_rs, id_rt, id_dest;
    logic       jump_miss, i_branch_miss, mem_stall;

    logic       pcw_f, irw_f, sif_f, sid_f, fif_f, fid_f, err_f;
    logic       pcw_n, irw_n, sif_n, sid_n, fif_n, fid_n, err_n;
    logic       pcw_w, irw_w, sif_w, sid_w, fif_w, fid_w, err_w;
    logic [1:0] hs_f, hs_n, hs_w;

    int n_compared   = 0;
    int n_mismatched = 0;

    // {pc_write, ir_write, stall_IFID, stall_IDEX, flush_IFID, flush_IDEX}
    localparam logic [5:0] C_RUN = 6'b110000;
    localparam logic [5:0] C_DHZ = 6'b001001;
    localparam logic [5:0] C_FRZ = 6'b001100;
    localparam logic [5:0] C_FLS = 6'b110011;

    wire [5:0] ctl_f = {pcw_f, irw_f, sif_f, sid_f, fif_f, fid_f};
    wire [5:0] ctl_n = {pcw_n, irw_n, sif_n, sid_n, fif_n, fid_n};
    wire [5:0] ctl_w = {pcw_w, irw_w, sif_w, sid_w, fif_w, fid_w};

`ifdef HAZARD_STATS_EN
    logic [15:0] st_f [3];
    logic [15:0] st_n [3];
    logic [15:0] st_w [3];
`endif

    always #5 clk = ~clk;

    hazard_scoreboard_unit dut_f (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_reg_write(id_reg_write), .id_dest(id_dest),
        .id_is_load(id_is_load), .jump_miss(jump_miss), .i_branch_miss(i_branch_miss),
        .mem_stall(mem_stall), .pc_write(pcw_f), .ir_write(irw_f), .stall_IFID(sif_f),
        .stall_IDEX(sid_f), .flush_IFID(fif_f), .flush_IDEX(fid_f), .hazard_state(hs_f),
        .hazard_error(err_f)
`ifdef HAZARD_STATS_EN
        , .stat_stall_cycles(st_f[0]), .stat_freeze_cycles(st_f[1]), .stat_flushes(st_f[2])
`endif
    );

    hazard_scoreboard_unit #(.DATA_FORWARDING(0)) dut_n (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_reg_write(id_reg_write), .id_dest(id_dest),
        .id_is_load(id_is_load), .jump_miss(jump_miss), .i_branch_miss(i_branch_miss),
        .mem_stall(mem_stall), .pc_write(pcw_n), .ir_write(irw_n), .stall_IFID(sif_n),
        .stall_IDEX(sid_n), .flush_IFID(fif_n), .flush_IDEX(fid_n), .hazard_state(hs_n),
        .hazard_error(err_n)
`ifdef HAZARD_STATS_EN
        , .stat_stall_cycles(st_n[0]), .stat_freeze_cycles(st_n[1]), .stat_flushes(st_n[2])
`endif
    );

    hazard_scoreboard_unit #(.STALL_TIMEOUT(4), .LOAD_USE_DELAY(6)) dut_w (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_reg_write(id_reg_write), .id_dest(id_dest),
        .id_is_load(id_is_load), .jump_miss(jump_miss), .i_branch_miss(i_branch_miss),
        .mem_stall(mem_stall), .pc_write(pcw_w), .ir_write(irw_w), .stall_IFID(sif_w),
        .stall_IDEX(sid_w), .flush_IFID(fif_w), .flush_IDEX(fid_w), .hazard_state(hs_w),
        .hazard_error(err_w)
`ifdef HAZARD_STATS_EN
        , .stat_stall_cycles(st_w[0]), .stat_freeze_cycles(st_w[1]), .stat_flushes(st_w[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one ID-stage cycle at the falling edge, then settle before sampling.
    task automatic apply(input logic v, input logic urs, input logic urt, input logic [1:0] rs,
                         input logic [1:0] rt, input logic rw, input logic [1:0] dst,
                         input logic ld, input logic jm, input logic bm, input logic ms);
        @(negedge clk);
        id_valid = v; id_use_rs = urs; id_use_rt = urt; id_rs = rs; id_rt = rt;
        id_reg_write = rw; id_dest = dst; id_is_load = ld;
        jump_miss = jm; i_branch_miss = bm; mem_stall = ms;
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_rs = 0; id_rt = 0;
        id_reg_write = 0; id_dest = 0; id_is_load = 0;
        jump_miss = 0; i_branch_miss = 0; mem_stall = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        do_reset();
        check("reset_ctl_f", ctl_f, C_RUN);
        check("reset_state_f", hs_f, 2'd0);
        check("reset_err_f", err_f, 1'b0);
        check("reset_ctl_n", ctl_n, C_RUN);
        check("reset_err_w", err_w, 1'b0);

        // Forwarding: ALU writer r1 then reader r1 -> no stall.
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd1, 0, 0, 0, 0);
        check("fwd_alu_writer", ctl_f, C_RUN);
        apply(1, 1, 0, 2'd1, 2'd0, 0, 2'd0, 0, 0, 0, 0);
        check("fwd_alu_reader", ctl_f, C_RUN);

        // Forwarding: load r2 then reader r2 -> exactly one bubble.
        do_reset();
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd2, 1, 0, 0, 0);
        check("fwd_ld_writer", ctl_f, C_RUN);
        apply(1, 1, 0, 2'd2, 2'd0, 0, 2'd0, 0, 0, 0, 0);
        check("fwd_ld_stall", ctl_f, C_DHZ);
        apply(1, 1, 0, 2'd2, 2'd0, 0, 2'd0, 0, 0, 0, 0);
        check("fwd_ld_resume", ctl_f, C_RUN);
        check("fwd_ld_state_data", hs_f, 2'd1);

        // Operand-use and valid gating: pending r2 named but not actually read.
        do_reset();
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd2, 1, 0, 0, 0);
        apply(1, 0, 1, 2'd2, 2'd0, 0, 2'd0, 0, 0, 0, 0);
        check("fwd_unused_rs", ctl_f, C_RUN);
        do_reset();
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd2, 1, 0, 0, 0);
        apply(0, 1, 1, 2'd2, 2'd2, 0, 2'd0, 0, 0, 0, 0);
        check("fwd_bubble_no_stall", ctl_f, C_RUN);

        // No forwarding: ADI r3 then reader rt=r3 -> three stall cycles.
        do_reset();
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd3, 0, 0, 0, 0);
        check("nofwd_writer", ctl_n, C_RUN);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 0);
            check($sformatf("nofwd_stall_%0d", i), ctl_n, C_DHZ);
        end
        apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 0);
        check("nofwd_resume", ctl_n, C_RUN);

        // No forwarding with a two-cycle memory freeze in the middle of the stall.
        do_reset();
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd3, 0, 0, 0, 0);
        apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 0);
        check("frz_stall_a", ctl_n, C_DHZ);
        apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 1);
        check("frz_cycle_1", ctl_n, C_FRZ);
        apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 1);
        check("frz_cycle_2", ctl_n, C_FRZ);
        check("frz_state_2", hs_n, 2'd2);
        apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 0);
        check("frz_stall_b", ctl_n, C_DHZ);
        check("frz_state_after", hs_n, 2'd2);
        apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 0);
        check("frz_stall_c", ctl_n, C_DHZ);
        apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 0);
        check("frz_resume", ctl_n, C_RUN);

        // Reset mid-operation clears pending counters.
        do_reset();
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd3, 0, 0, 0, 0);
        do_reset();
        apply(1, 0, 1, 2'd0, 2'd3, 0, 2'd0, 0, 0, 0, 0);
        check("midreset_run", ctl_n, C_RUN);

        // Freeze beats flush; flush beats a pending load-use and squashes the writer.
        do_reset();
        apply(0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 1, 0, 1);
        check("prio_freeze_over_flush", ctl_f, C_FRZ);
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd2, 1, 0, 0, 0);
        apply(1, 1, 0, 2'd2, 2'd0, 1, 2'd0, 1, 0, 1, 0);
        check("flush_over_dhaz", ctl_f, C_FLS);
        apply(1, 1, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0, 0);
        check("squashed_no_cnt", ctl_f, C_RUN);
        check("flush_state", hs_f, 2'd3);

        // Watchdog: 6-cycle load delay, timeout 4.
        do_reset();
        apply(1, 0, 0, 2'd0, 2'd0, 1, 2'd1, 1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            apply(1, 1, 0, 2'd1, 2'd0, 0, 2'd0, 0, 0, 0, 0);
            check($sformatf("wd_stall_%0d", k), ctl_w, C_DHZ);
            check($sformatf("wd_err_%0d", k), err_w, (k >= 5) ? 1'b1 : 1'b0);
        end
        apply(1, 1, 0, 2'd1, 2'd0, 0, 2'd0, 0, 0, 0, 0);
        check("wd_resume", ctl_w, C_RUN);
        check("wd_err_sticky", err_w, 1'b1);
        idle();
        check("wd_err_sticky_idle", err_w, 1'b1);
        do_reset();
        check("wd_err_cleared", err_w, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline hazard control unit. It replaces per-stage destination comparisons with a per-register pending-cycle scoreboard.
- Sits beside the ID stage and drives PC/IF-ID/ID-EX write, stall and flush controls.
- Generalised in register count, forwarding mode and per-class use latency.
- Adds an external memory freeze input, a stall watchdog and a debug state.

Parameters:
- NUM_REGS, 4, number of architectural registers.
- REG_AW, 2, register address width; must satisfy 2**REG_AW >= NUM_REGS.
- DATA_FORWARDING, 1, 1 = bypass network present; 0 = consumers wait for register-file write.
- ALU_USE_DELAY, 0, bubbles after a non-load writer when forwarding.
- LOAD_USE_DELAY, 1, bubbles after a load when forwarding.
- NOFWD_USE_DELAY, 3, bubbles after any writer when DATA_FORWARDING=0.
- STALL_TIMEOUT, 64, consecutive data-stall cycles before hazard_error is set.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real (non-bubble) instruction.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_rs  input  REG_AW  rs address.
- id_rt  input  REG_AW  rt address.
- id_reg_write  input  1  ID instruction writes a register.
- id_dest  input  REG_AW  destination address.
- id_is_load  input  1  ID instruction is LWD.
- jump_miss  input  1  unconditional-jump misprediction.
- i_branch_miss  input  1  conditional-branch misprediction.
- mem_stall  input  1  memory busy; freeze the whole pipeline.
- pc_write  output  1  PC update enable.
- ir_write  output  1  IF/ID instruction-register write enable.
- stall_IFID  output  1  hold IF/ID register.
- stall_IDEX  output  1  hold ID/EX register.
- flush_IFID  output  1  IF/ID → nop.
- flush_IDEX  output  1  ID/EX → nop.
- hazard_state  output  2  0 RUN, 1 DATA_STALL, 2 MEM_FREEZE, 3 FLUSH.
- hazard_error  output  1  sticky watchdog flag.

Behaviour:

Scoreboard
- cnt[r], r < NUM_REGS, each $clog2(max delay + 1) bits.
- Reset: all cnt = 0, state RUN, stall_run = 0, hazard_error = 0.

Combinational per cycle
- freeze = mem_stall.
- flush = jump_miss | i_branch_miss.
- dhaz = id_valid & ((id_use_rs & cnt[id_rs] != 0) | (id_use_rt & cnt[id_rt] != 0)).
- Addresses >= NUM_REGS read as cnt 0.

Output priority: freeze > flush > dhaz > run.
- freeze: pc_write=0, ir_write=0, stall_IFID=1, stall_IDEX=1, flush_*=0.
- flush: pc_write=1, ir_write=1, flush_IFID=1, flush_IDEX=1, stall_*=0.
- dhaz: pc_write=0, ir_write=0, stall_IFID=1, flush_IDEX=1 (bubble), stall_IDEX=0.
- run: pc_write=1, ir_write=1, all stall/flush = 0.
- Simultaneous flush and dhaz: flush wins; the squashed ID instruction never issues.

Issue and counter update
- issue = id_valid & id_reg_write & ~freeze & ~flush & ~dhaz.
- Issue delay L:
  - DATA_FORWARDING=1: id_is_load ? LOAD_USE_DELAY : ALU_USE_DELAY.
  - DATA_FORWARDING=0: NOFWD_USE_DELAY.
- Sequential update:
  - freeze: all cnt hold.
  - otherwise: every nonzero cnt decrements by 1; on issue, cnt[id_dest] <= L, overriding the decrement on the same register.
- Result: a dependent instruction immediately following a writer stalls exactly L cycles. L=0 never stalls.

State and watchdog
- hazard_state registers the priority class of the previous cycle; it is debug only and does not feed the outputs.
- stall_run counts consecutive dhaz cycles and clears on any non-dhaz cycle.
- When stall_run reaches STALL_TIMEOUT, hazard_error <= 1; it is sticky until reset.
- freeze cycles neither count nor clear stall_run.

Reset mid-operation: next cycle all counters are 0 and outputs show run.

Optional Feature:
- Macro HAZARD_STATS_EN.
- With it: add outputs stat_stall_cycles[15:0], stat_freeze_cycles[15:0] and stat_flushes[15:0]. Each is a saturating counter incremented on dhaz, freeze or flush cycles respectively (priority-exclusive); all clear on reset.
- Without it: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (constants.v): hazard_state encodings (HZ_RUN, HZ_DATA, HZ_FREEZE, HZ_FLUSH) and the default delay constants.
- Natural sub-module: hazard_pending_counter, one saturating down-counter with load, hold and decrement. Instantiate it NUM_REGS times in a generate loop.

Test Plan:
- Forwarding, ADD writes r1, next instruction reads r1 → no stall; pc_write=1 throughout.
- Forwarding, LWD writes r2, next instruction reads r2 → exactly 1 cycle with stall_IFID=1, flush_IDEX=1, pc_write=0, then run.
- DATA_FORWARDING=0, ADI writes r3, next instruction reads r3 as rt → 3 stall cycles.
- DATA_FORWARDING=0, same case with mem_stall=1 for 2 cycles in the middle → 3 dhaz cycles in total; cnt held during the freeze; hazard_state shows 2 during the freeze.
- Load-use hazard pending while i_branch_miss=1 → flush_IFID=flush_IDEX=1, pc_write=1, no stall; the squashed instruction does not set cnt.
- STALL_TIMEOUT=4, force cnt nonzero with a long delay parameter (e.g. LOAD_USE_DELAY=6) → hazard_error rises after 4 stall cycles and stays 1 until reset.
